// File: rtl/ads86xx_spi_ctrl.sv
// SPI controller for ADS86xx-family SAR ADCs.
// Resets the ADC, sends the config frames, then reads conversion results.
module ads86xx_spi_ctrl #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned CLK_DIV  = 1,
   parameter int unsigned NCFG     = 3,
   parameter int unsigned CONV_CYC = 60,
   parameter int unsigned RST_CYC  = 50,
   parameter int unsigned DUAL_SDO = 0,
   parameter int unsigned FREE_RUN = 1
) (
   input  logic                                     clk_ref,
   input  logic                                     sys_rstn,
   input  logic [32*((NCFG > 0) ? NCFG : 1)-1:0]    cfg_words,
   input  logic                                     trig,
   output logic                                     convst_csn,
   output logic                                     ads_rstn,
   output logic                                     ads_sclk,
   output logic                                     ads_sdi,
   input  logic                                     ads_sdo0,
   input  logic                                     ads_sdo1,
   output logic                                     dvalid,
   output logic [DATA_W-1:0]                        dout,
   output logic                                     cfg_done,
   output logic                                     busy,
   output logic                                     ovr
);

   localparam int unsigned MAXC = (RST_CYC > CONV_CYC) ? RST_CYC : CONV_CYC;
   localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int unsigned HW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BW   = $clog2(32 + 1);
   localparam int unsigned DNB  = (DUAL_SDO != 0) ? DATA_W / 2 : DATA_W;

   typedef enum logic [2:0] {
      RSTLO, RSTWAIT, CONV, SETUP, SHIFT, DONE, IDLE
   } state_e;

   state_e              state_q;
   logic [CW-1:0]       cnt_q;
   logic [HW-1:0]       hcnt_q;
   logic [BW-1:0]       bcnt_q;
   logic [3:0]          fcnt_q;
   logic [30:0]         tx_q;
   logic [DATA_W-1:0]   rx_q;

   logic [31:0]         cfg_sel;
   logic [DATA_W-1:0]   rx_next;
   logic [BW-1:0]       frame_nb;
   logic                last_cfg;
   logic                half_end;

   // Frame selection, readout shift and frame length
   always_comb begin
      cfg_sel  = 32'(cfg_words >> {fcnt_q, 5'd0});
      rx_next  = {rx_q[DATA_W-2:0], ads_sdo0};
      if (DUAL_SDO != 0) rx_next = {rx_q[DATA_W-3:0], ads_sdo1, ads_sdo0};
      frame_nb = cfg_done ? BW'(DNB) : BW'(32);
      last_cfg = (32'(fcnt_q) + 32'd1) == NCFG;
      half_end = hcnt_q == HW'(CLK_DIV - 1);
   end

   always_ff @(posedge clk_ref or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state_q    <= RSTLO;
         cnt_q      <= '0;
         hcnt_q     <= '0;
         bcnt_q     <= '0;
         fcnt_q     <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         convst_csn <= 1'b1;
         ads_rstn   <= 1'b0;
         ads_sclk   <= 1'b0;
         ads_sdi    <= 1'b0;
         dvalid     <= 1'b0;
         dout       <= '0;
         cfg_done   <= 1'b0;
         busy       <= 1'b0;
         ovr        <= 1'b0;
      end else begin
         dvalid <= 1'b0;
         // Any request outside IDLE is dropped and flagged
         ovr    <= (FREE_RUN == 0) && trig && (state_q != IDLE);
         case (state_q)
            RSTLO: begin
               if (cnt_q == CW'(RST_CYC - 1)) begin
                  cnt_q    <= '0;
                  ads_rstn <= 1'b1;
                  state_q  <= RSTWAIT;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            RSTWAIT: begin
               if (cnt_q == CW'(RST_CYC - 1)) begin
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= CONV;
                  if (NCFG == 0) cfg_done <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            CONV: begin
               if (cnt_q == CW'(CONV_CYC - 1)) begin
                  cnt_q      <= '0;
                  hcnt_q     <= '0;
                  bcnt_q     <= '0;
                  convst_csn <= 1'b0;
                  tx_q       <= cfg_done ? 31'd0 : cfg_sel[30:0];
                  ads_sdi    <= cfg_done ? 1'b0 : cfg_sel[31];
                  state_q    <= SETUP;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            SETUP: begin
               if (half_end) begin
                  hcnt_q   <= '0;
                  ads_sclk <= 1'b1;
                  rx_q     <= rx_next;
                  bcnt_q   <= BW'(1);
                  state_q  <= SHIFT;
               end else begin
                  hcnt_q <= hcnt_q + HW'(1);
               end
            end
            SHIFT: begin
               if (!half_end) begin
                  hcnt_q <= hcnt_q + HW'(1);
               end else begin
                  hcnt_q <= '0;
                  if (ads_sclk) begin
                     // Falling edge: present the next SDI bit
                     ads_sclk <= 1'b0;
                     ads_sdi  <= tx_q[30];
                     tx_q     <= {tx_q[29:0], 1'b0};
                  end else if (bcnt_q == frame_nb) begin
                     convst_csn <= 1'b1;
                     ads_sdi    <= 1'b0;
                     state_q    <= DONE;
                     if (cfg_done) begin
                        dout   <= rx_q;
                        dvalid <= 1'b1;
                     end else begin
                        fcnt_q <= fcnt_q + 4'd1;
                        if (last_cfg) cfg_done <= 1'b1;
                     end
                  end else begin
                     ads_sclk <= 1'b1;
                     rx_q     <= rx_next;
                     bcnt_q   <= bcnt_q + BW'(1);
                  end
               end
            end
            DONE: begin
               cnt_q <= '0;
               if ((FREE_RUN != 0) || !cfg_done) begin
                  state_q <= CONV;
               end else begin
                  busy    <= 1'b0;
                  state_q <= IDLE;
               end
            end
            IDLE: begin
               cnt_q <= '0;
               if (trig) begin
                  busy    <= 1'b1;
                  state_q <= CONV;
               end
            end
            default: state_q <= RSTLO;
         endcase
      end
   end

endmodule
